// File: rtl/bp_cache_dma_axil_ctrl.sv
// Splits cache-block DMA packets into single-beat AXI4-Lite reads/writes, one beat outstanding.
// Optional sticky response-error flag is built only with BP_DMA_AXIL_ERR_LATCH_EN defined.
module bp_cache_dma_axil_ctrl #(
  parameter int daddr_width_p     = 28,
  parameter int axil_addr_width_p = 28,
  parameter int axil_data_width_p = 64,
  parameter int block_width_p     = 512
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [daddr_width_p:0]         dma_pkt_i,
  input  logic                           dma_pkt_v_i,
  output logic                           dma_pkt_yumi_o,
  output logic [axil_data_width_p-1:0]   dma_data_o,
  output logic                           dma_data_v_o,
  input  logic                           dma_data_ready_and_i,
  input  logic [axil_data_width_p-1:0]   dma_data_i,
  input  logic                           dma_data_v_i,
  output logic                           dma_data_yumi_o,
  output logic [axil_addr_width_p-1:0]   araddr_o,
  output logic [2:0]                     arprot_o,
  output logic                           arvalid_o,
  input  logic                           arready_i,
  input  logic [axil_data_width_p-1:0]   rdata_i,
  input  logic [1:0]                     rresp_i,
  input  logic                           rvalid_i,
  output logic                           rready_o,
  output logic [axil_addr_width_p-1:0]   awaddr_o,
  output logic [2:0]                     awprot_o,
  output logic                           awvalid_o,
  input  logic                           awready_i,
  output logic [axil_data_width_p-1:0]   wdata_o,
  output logic [axil_data_width_p/8-1:0] wstrb_o,
  output logic                           wvalid_o,
  input  logic                           wready_i,
  input  logic [1:0]                     bresp_i,
  input  logic                           bvalid_i,
  output logic                           bready_o,
  output logic                           busy_o,
  output logic                           error_o
);

  localparam int beats_lp    = block_width_p / axil_data_width_p;
  localparam int lg_beats_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int blk_off_lp  = $clog2(block_width_p / 8);
  localparam int beat_off_lp = $clog2(axil_data_width_p / 8);
  localparam logic [daddr_width_p-1:0] blk_mask_lp = daddr_width_p'((64'd1 << blk_off_lp) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RD_OUT, WR_DATA, WR_REQ, WR_RESP
  } state_e;

  state_e                         state;
  logic [lg_beats_lp-1:0]         beat;
  logic [daddr_width_p-1:0]       base;
  logic [daddr_width_p-1:0]       beat_addr;
  logic [axil_data_width_p-1:0]   data_r;
  logic                           last_beat;
  logic                           aw_done;
  logic                           w_done;

  assign last_beat = (beat == lg_beats_lp'(beats_lp - 1));
  assign beat_addr = base + (daddr_width_p'(beat) << beat_off_lp);
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done   = ~awvalid_o | awready_i;
  assign w_done    = ~wvalid_o | wready_i;

  assign dma_pkt_yumi_o  = dma_pkt_v_i & (state == IDLE);
  assign dma_data_yumi_o = dma_data_v_i & (state == WR_DATA);
  assign dma_data_o      = data_r;
  assign wdata_o         = data_r;
  assign wstrb_o         = '1;
  assign araddr_o        = axil_addr_width_p'(beat_addr);
  assign awaddr_o        = axil_addr_width_p'(beat_addr);
  assign arprot_o        = 3'b000;
  assign awprot_o        = 3'b000;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      beat         <= '0;
      base         <= '0;
      data_r       <= '0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      dma_data_v_o <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dma_pkt_v_i) begin
          base   <= dma_pkt_i[daddr_width_p-1:0] & ~blk_mask_lp;
          beat   <= '0;
          busy_o <= 1'b1;
          if (dma_pkt_i[daddr_width_p]) begin
            state <= WR_DATA;
          end else begin
            state     <= RD_ADDR;
            arvalid_o <= 1'b1;
          end
        end
        RD_ADDR: if (arready_i) begin
          arvalid_o <= 1'b0;
          rready_o  <= 1'b1;
          state     <= RD_DATA;
        end
        RD_DATA: if (rvalid_i) begin
          rready_o     <= 1'b0;
          data_r       <= rdata_i;
          dma_data_v_o <= 1'b1;
          state        <= RD_OUT;
        end
        RD_OUT: if (dma_data_ready_and_i) begin
          dma_data_v_o <= 1'b0;
          if (last_beat) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            beat      <= beat + 1'b1;
            arvalid_o <= 1'b1;
            state     <= RD_ADDR;
          end
        end
        WR_DATA: if (dma_data_v_i) begin
          data_r    <= dma_data_i;
          awvalid_o <= 1'b1;
          wvalid_o  <= 1'b1;
          state     <= WR_REQ;
        end
        WR_REQ: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (aw_done && w_done) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: if (bvalid_i) begin
          bready_o <= 1'b0;
          if (last_beat) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            beat  <= beat + 1'b1;
            state <= WR_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_DMA_AXIL_ERR_LATCH_EN
  logic error_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if ((rvalid_i && rready_o && (rresp_i != 2'b00)) ||
                 (bvalid_i && bready_o && (bresp_i != 2'b00))) begin
      error_r <= 1'b1;
    end
  end
  assign error_o = error_r;
`else
  logic unused_resp;
  assign unused_resp = ^{rresp_i, bresp_i};
  assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cache_dma_axil_ctrl.sv
// Directed bench for bp_cache_dma_axil_ctrl with a small behavioural AXI4-Lite slave and evict source.
module tb_bp_cache_dma_axil_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [28:0] dma_pkt = '0;
  logic        dma_pkt_v = 1'b0;
  logic        dma_pkt_yumi;
  logic [63:0] dma_data_out;
  logic        dma_data_out_v;
  logic        dma_rdy = 1'b1;
  logic [63:0] dma_data_in;
  logic        dma_data_in_v;
  logic        dma_data_yumi;
  logic [27:0] araddr, awaddr;
  logic [2:0]  arprot, awprot;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  rresp, bresp;
  logic        busy, error;

  bp_cache_dma_axil_ctrl dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(dma_pkt), .dma_pkt_v_i(dma_pkt_v), .dma_pkt_yumi_o(dma_pkt_yumi),
    .dma_data_o(dma_data_out), .dma_data_v_o(dma_data_out_v), .dma_data_ready_and_i(dma_rdy),
    .dma_data_i(dma_data_in), .dma_data_v_i(dma_data_in_v), .dma_data_yumi_o(dma_data_yumi),
    .araddr_o(araddr), .arprot_o(arprot), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awprot_o(awprot), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .busy_o(busy), .error_o(error)
  );

  always #5 clk = ~clk;

`ifdef BP_DMA_AXIL_ERR_LATCH_EN
  localparam logic err_en = 1'b1;
`else
  localparam logic err_en = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave / evict-source model state
  int aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  int b_cnt = 0, err_at = -1, ev_cnt = 0, ev_base = 0, aw_hi = 0, w_hi = 0;
  logic aw_got = 1'b0, w_got = 1'b0, ev_en = 1'b0;
  logic [27:0] ar_q[$];
  logic [27:0] aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] fill_q[$];
  logic [7:0]  strb_q[$];

  assign arready       = 1'b1;
  assign awready       = awvalid && (aw_cnt >= aw_delay);
  assign wready        = wvalid && (w_cnt >= w_delay);
  assign dma_data_in   = 64'(ev_cnt - ev_base);
  assign dma_data_in_v = ev_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      bvalid <= 1'b0; bresp <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_q.push_back(araddr);
        rvalid <= 1'b1;
        rdata  <= 64'hDEAD_0000_0000_0000 | 64'(araddr);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
      if (dma_data_out_v && dma_rdy) fill_q.push_back(dma_data_out);
      if (dma_data_yumi) ev_cnt <= ev_cnt + 1;
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (awvalid && awready) begin aw_q.push_back(awaddr); aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_q.push_back(wdata); strb_q.push_back(wstrb); w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
        bresp  <= (b_cnt == err_at) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
    end
  end

  task automatic send_pkt(input logic wr, input logic [27:0] addr);
    @(negedge clk);
    dma_pkt = {wr, addr};
    dma_pkt_v = 1'b1;
    #1 chk("pkt_yumi", 64'(dma_pkt_yumi), 64'd1);
    @(negedge clk);
    dma_pkt_v = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_cnt < target && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (b_cnt < target) chk("b_timeout", 64'(b_cnt), 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, a0, f0, w0, b0, awh0, wh0;
    logic [63:0] exp_fill;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", 64'({arvalid, rready, awvalid, wvalid, bready, dma_data_out_v,
                         dma_pkt_yumi, dma_data_yumi, busy, error}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // zero-wait read of a full block
    a0 = ar_q.size(); f0 = fill_q.size();
    send_pkt(1'b0, 28'h0001040);
    wait_idle(cyc);
    chk("rd_busy_cycles", 64'(cyc), 64'd24);
    chk("rd_ar_count", 64'(ar_q.size() - a0), 64'd8);
    chk("rd_fill_count", 64'(fill_q.size() - f0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd_araddr%0d", i), 64'(ar_q[a0+i]), 64'h1040 + 64'(8*i));
      chk($sformatf("rd_fill%0d", i), fill_q[f0+i], 64'hDEAD_0000_0000_1040 + 64'(8*i));
    end
    chk("arprot", 64'(arprot), 64'd0);

    // zero-wait write of a full block, evict beats 0..7
    a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt;
    ev_base = ev_cnt; ev_en = 1'b1;
    send_pkt(1'b1, 28'h0002000);
    wait_idle(cyc);
    ev_en = 1'b0;
    chk("wr_busy_cycles", 64'(cyc), 64'd24);
    chk("wr_b_count", 64'(b_cnt - b0), 64'd8);
    chk("wr_aw_count", 64'(aw_q.size() - a0), 64'd8);
    chk("wr_w_count", 64'(w_q.size() - w0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_awaddr%0d", i), 64'(aw_q[a0+i]), 64'h2000 + 64'(8*i));
      chk($sformatf("wr_wdata%0d", i), w_q[w0+i], 64'(i));
      chk($sformatf("wr_wstrb%0d", i), 64'(strb_q[w0+i]), 64'hFF);
    end
    chk("awprot", 64'(awprot), 64'd0);

    // AW ready delayed by 3 cycles, W ready immediately
    aw_delay = 3; w_delay = 0;
    a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt; awh0 = aw_hi; wh0 = w_hi;
    ev_base = ev_cnt; ev_en = 1'b1;
    send_pkt(1'b1, 28'h0006000);
    wait_idle(cyc);
    ev_en = 1'b0; aw_delay = 0;
    chk("dly_busy_cycles", 64'(cyc), 64'd48);
    chk("dly_aw_high", 64'(aw_hi - awh0), 64'd32);
    chk("dly_w_high", 64'(w_hi - wh0), 64'd8);
    chk("dly_aw_count", 64'(aw_q.size() - a0), 64'd8);
    chk("dly_w_count", 64'(w_q.size() - w0), 64'd8);
    chk("dly_b_count", 64'(b_cnt - b0), 64'd8);
    chk("dly_last_awaddr", 64'(aw_q[a0+7]), 64'h6038);
    chk("dly_last_wdata", w_q[w0+7], 64'd7);

    // fill beat stalled by the cache for 5 cycles
    dma_rdy = 1'b0;
    a0 = ar_q.size(); f0 = fill_q.size();
    send_pkt(1'b0, 28'h0004000);
    cyc = 0;
    while (!dma_data_out_v && cyc < 50) begin cyc++; @(negedge clk); end
    exp_fill = 64'hDEAD_0000_0000_4000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_v%0d", i), 64'(dma_data_out_v), 64'd1);
      chk($sformatf("stall_data%0d", i), dma_data_out, exp_fill);
      chk($sformatf("stall_ar%0d", i), 64'(ar_q.size() - a0), 64'd1);
      @(negedge clk);
    end
    dma_rdy = 1'b1;
    wait_idle(cyc);
    chk("stall_fill_count", 64'(fill_q.size() - f0), 64'd8);
    chk("stall_fill0", fill_q[f0], exp_fill);
    chk("stall_fill7", fill_q[f0+7], 64'hDEAD_0000_0000_4038);

    // error response on beat 5 of a write
    b0 = b_cnt; err_at = b_cnt + 5;
    ev_base = ev_cnt; ev_en = 1'b1;
    send_pkt(1'b1, 28'h0005000);
    wait_b(b0 + 5);
    chk("err_before", 64'(error), 64'd0);
    wait_b(b0 + 6);
    chk("err_after", 64'(error), 64'(err_en));
    wait_idle(cyc);
    ev_en = 1'b0; err_at = -1;
    chk("err_b_count", 64'(b_cnt - b0), 64'd8);
    chk("err_held", 64'(error), 64'(err_en));

    // reset pulsed mid-write at beat 3
    b0 = b_cnt;
    ev_base = ev_cnt; ev_en = 1'b1;
    send_pkt(1'b1, 28'h0007000);
    wait_b(b0 + 3);
    cyc = 0;
    while (!awvalid && cyc < 50) begin cyc++; @(negedge clk); end
    chk("mid_awvalid", 64'(awvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, dma_data_out_v,
                               dma_data_yumi, busy}), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    ev_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = ar_q.size(); f0 = fill_q.size();
    send_pkt(1'b0, 28'h0003000);
    wait_idle(cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd24);
    chk("post_rst_ar_count", 64'(ar_q.size() - a0), 64'd8);
    chk("post_rst_ar0", 64'(ar_q[a0]), 64'h3000);
    chk("post_rst_fill0", fill_q[f0], 64'hDEAD_0000_0000_3000);
    chk("post_rst_fill_count", 64'(fill_q.size() - f0), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
